// File: rtl/soft_trig_pkg.sv
// Shared types and default sizes for the soft-trigger source path.
package soft_trig_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HIGH,
      ST_GAP
   } state_e;

   localparam int DEF_PULSE_CYCLES = 2;
   localparam int DEF_GAP_CYCLES   = 2;
   localparam int DEF_PEND_BITS    = 4;
   localparam int PERIOD_W         = 32;
   localparam int ISSUE_W          = 32;

   // One down-counter times both the HIGH and GAP phases, so it must hold the larger of the two.
   function automatic int cntWidth(input int pulse, input int gap);
      return $clog2(((pulse > gap) ? pulse : gap) + 1);
   endfunction

endpackage

// File: rtl/soft_trig_timer.sv
// Periodic tick source: one-cycle tick every period_i cycles, period_i == 0 disables it.
module soft_trig_timer
   import soft_trig_pkg::*;
#(
   parameter int WIDTH = PERIOD_W
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [WIDTH-1:0] period_i,
   output logic             tick_o
);

   logic [WIDTH-1:0] timer_q;
   logic [WIDTH-1:0] timer_d;

   // A shrinking period that leaves the timer out of range restarts it at zero without a tick.
   always_comb begin
      tick_o  = 1'b0;
      timer_d = timer_q + WIDTH'(1);
      if (period_i == '0) begin
         timer_d = '0;
      end else if (timer_q >= period_i) begin
         timer_d = '0;
      end else if (timer_q == period_i - WIDTH'(1)) begin
         tick_o  = 1'b1;
         timer_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

endmodule

// File: rtl/soft_trig_gen.sv
// Turns software strobes and periodic ticks into spaced soft_o pulses for the clk33->clk250 pipe.
module soft_trig_gen
   import soft_trig_pkg::*;
#(
   parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
   parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
   parameter int PEND_BITS    = DEF_PEND_BITS
) (
   input  logic                 clk33_i,
   input  logic                 rst_n_i,
   input  logic                 soft_req_i,
   input  logic [PERIOD_W-1:0]  period_i,
   output logic                 soft_o,
   output logic                 busy_o,
   output logic [PEND_BITS-1:0] pending_o,
   output logic                 dropped_o,
   output logic [ISSUE_W-1:0]   issued_o
);

   localparam int CNT_W = cntWidth(PULSE_CYCLES, GAP_CYCLES);
   localparam logic [CNT_W-1:0]     PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0]     GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [PEND_BITS-1:0] PEND_MAX   = '1;

   state_e               state_q;
   logic                 soft_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [PEND_BITS-1:0] pending_q;
   logic [PEND_BITS-1:0] pending_d;
   logic                 dropped_q;
   logic                 dropped_d;
   logic [ISSUE_W-1:0]   issued_q;

   logic                 tick;
   logic [1:0]           req;
   logic                 take;
   logic [PEND_BITS+1:0] pendSum;

   soft_trig_timer #(
      .WIDTH(PERIOD_W)
   ) u_timer (
      .clk_i   (clk33_i),
      .rst_n_i (rst_n_i),
      .period_i(period_i),
      .tick_o  (tick)
   );

   // Requests and the IDLE issue are summed together, so a full queue that issues while
   // taking one new request loses nothing.
   always_comb begin
      req       = {1'b0, soft_req_i} + {1'b0, tick};
      take      = (state_q == ST_IDLE) && ((pending_q != '0) || (req != 2'd0));
      pendSum   = {2'b00, pending_q} + {{PEND_BITS{1'b0}}, req}
                - {{(PEND_BITS + 1){1'b0}}, take};
      dropped_d = (pendSum > {2'b00, PEND_MAX});
      pending_d = dropped_d ? PEND_MAX : pendSum[PEND_BITS-1:0];
   end

   always_ff @(posedge clk33_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_IDLE;
         soft_q    <= 1'b0;
         cnt_q     <= '0;
         pending_q <= '0;
         dropped_q <= 1'b0;
         issued_q  <= '0;
      end else begin
         pending_q <= pending_d;
         dropped_q <= dropped_d;
         case (state_q)
            ST_IDLE: begin
               if (take) begin
                  state_q <= ST_HIGH;
                  soft_q  <= 1'b1;
                  cnt_q   <= PULSE_LAST;
               end
            end
            ST_HIGH: begin
               // Only a completed pulse counts; a reset in this state discards it.
               if (cnt_q == '0) begin
                  state_q  <= ST_GAP;
                  soft_q   <= 1'b0;
                  cnt_q    <= GAP_LAST;
                  issued_q <= issued_q + ISSUE_W'(1);
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_GAP: begin
               if (cnt_q == '0) begin
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               soft_q  <= 1'b0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign soft_o    = soft_q;
   assign busy_o    = (state_q != ST_IDLE) || (pending_q != '0);
   assign pending_o = pending_q;
   assign dropped_o = dropped_q;
   assign issued_o  = issued_q;

endmodule

// File: tb/tb_soft_trig_gen.sv
// Bench for soft_trig_gen: timestamp-based reference model checked every cycle, plus directed scenarios.
module tb_soft_trig_gen;

   localparam int P    = 2;
   localparam int G    = 2;
   localparam int PB   = 4;
   localparam int PMAX = 15;

   logic        clk = 1'b0;
   logic        rstN;
   logic        softReq;
   logic        softReqS;
   logic [31:0] period;
   logic [31:0] periodS;

   logic          softO, busyO, droppedO;
   logic [PB-1:0] pendingO;
   logic [31:0]   issuedO;

   logic          sSoftO, sBusyO, sDroppedO;
   logic [1:0]    sPendingO;
   logic [31:0]   sIssuedO;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   soft_trig_gen #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .PEND_BITS(PB)) dut (
      .clk33_i   (clk),
      .rst_n_i   (rstN),
      .soft_req_i(softReq),
      .period_i  (period),
      .soft_o    (softO),
      .busy_o    (busyO),
      .pending_o (pendingO),
      .dropped_o (droppedO),
      .issued_o  (issuedO)
   );

   soft_trig_gen #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .PEND_BITS(2)) dutSmall (
      .clk33_i   (clk),
      .rst_n_i   (rstN),
      .soft_req_i(softReqS),
      .period_i  (periodS),
      .soft_o    (sSoftO),
      .busy_o    (sBusyO),
      .pending_o (sPendingO),
      .dropped_o (sDroppedO),
      .issued_o  (sIssuedO)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: tracks issue timestamps rather than FSM states.
   int          cyc = 0;
   bit          modelValid = 1'b0;
   int          pendM;
   int          lastIssue;
   int          nextFree;
   logic [31:0] issuedM;
   bit          dropExp;
   int          timerStart;
   int          lastPeriod;
   int          perI, span, val, tickM, reqM, sumM;
   bit          takeM;

   always @(negedge clk) begin
      if (modelValid) begin
         checkOutput("soft_o", {31'd0, softO},
                     {31'd0, ((cyc - lastIssue) >= 1) && ((cyc - lastIssue) <= P)});
         checkOutput("busy_o", {31'd0, busyO}, {31'd0, (cyc < nextFree) || (pendM != 0)});
         checkOutput("pending_o", {28'd0, pendingO}, 32'(pendM));
         checkOutput("dropped_o", {31'd0, droppedO}, {31'd0, dropExp});
         checkOutput("issued_o", issuedO, issuedM);
      end
      if (!rstN) begin
         pendM      = 0;
         lastIssue  = -1000;
         nextFree   = cyc + 1;
         issuedM    = '0;
         dropExp    = 1'b0;
         timerStart = cyc + 1;
         lastPeriod = int'(period);
         modelValid = 1'b1;
      end else if (modelValid) begin
         perI = int'(period);
         if (perI == 0) begin
            tickM      = 0;
            timerStart = cyc + 1;
         end else begin
            span = (lastPeriod == 0) ? 1 : lastPeriod;
            val  = (cyc - timerStart) % span;
            if (val >= perI) begin
               tickM      = 0;
               timerStart = cyc + 1;
            end else begin
               tickM      = (val == perI - 1) ? 1 : 0;
               timerStart = cyc - val;
            end
         end
         lastPeriod = perI;
         if (cyc - lastIssue == P) issuedM = issuedM + 32'd1;
         reqM  = int'(softReq) + tickM;
         takeM = (cyc >= nextFree) && (pendM + reqM > 0);
         if (takeM) begin
            lastIssue = cyc;
            nextFree  = cyc + P + G + 1;
         end
         sumM    = pendM + reqM - int'(takeM);
         dropExp = (sumM > PMAX);
         pendM   = dropExp ? PMAX : sumM;
      end
      cyc++;
   end

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) nextCycle();
   endtask

   task automatic applyStimulus(input int nCycles);
      softReq = 1'b1;
      waitCycles(nCycles);
      softReq = 1'b0;
   endtask

   int peakS;
   int dropsS;

   initial begin
      rstN     = 1'b0;
      softReq  = 1'b0;
      softReqS = 1'b0;
      period   = '0;
      periodS  = '0;
      waitCycles(3);
      rstN = 1'b1;
      checkOutput("reset soft_o", {31'd0, softO}, 32'd0);
      checkOutput("reset issued_o", issuedO, 32'd0);
      checkOutput("reset pending_o", {28'd0, pendingO}, 32'd0);
      waitCycles(3);

      $display("[TB] single strobe");
      applyStimulus(1);
      checkOutput("t1 soft +1", {31'd0, softO}, 32'd1);
      checkOutput("t1 pending +1", {28'd0, pendingO}, 32'd0);
      nextCycle();
      checkOutput("t1 soft +2", {31'd0, softO}, 32'd1);
      nextCycle();
      checkOutput("t1 soft +3", {31'd0, softO}, 32'd0);
      checkOutput("t1 issued", issuedO, 32'd1);
      nextCycle();
      checkOutput("t1 busy +4", {31'd0, busyO}, 32'd1);
      nextCycle();
      checkOutput("t1 busy +5", {31'd0, busyO}, 32'd0);
      waitCycles(2);

      $display("[TB] five back-to-back strobes");
      applyStimulus(5);
      checkOutput("t2 pending peak", {28'd0, pendingO}, 32'd4);
      waitCycles(25);
      checkOutput("t2 issued", issuedO, 32'd6);
      checkOutput("t2 busy", {31'd0, busyO}, 32'd0);

      $display("[TB] saturation on 2-bit pending counter");
      peakS    = 0;
      dropsS   = 0;
      softReqS = 1'b1;
      for (int i = 0; i < 40; i++) begin
         nextCycle();
         if (i == 6) softReqS = 1'b0;
         if (int'(sPendingO) > peakS) peakS = int'(sPendingO);
         if (sDroppedO === 1'b1) dropsS++;
      end
      checkOutput("t3 pending peak", 32'(peakS), 32'd3);
      checkOutput("t3 dropped cycles", 32'(dropsS), 32'd2);
      checkOutput("t3 issued", sIssuedO, 32'd5);
      checkOutput("t3 busy", {31'd0, sBusyO}, 32'd0);

      $display("[TB] periodic trigger");
      period = 32'd100;
      waitCycles(399);
      checkOutput("t4 issued after 3 ticks", issuedO, 32'd9);
      applyStimulus(1);
      checkOutput("t4 soft +400", {31'd0, softO}, 32'd1);
      checkOutput("t4 pending +400", {28'd0, pendingO}, 32'd1);
      waitCycles(4);
      checkOutput("t4 soft +404", {31'd0, softO}, 32'd0);
      nextCycle();
      checkOutput("t4 soft +405", {31'd0, softO}, 32'd1);
      checkOutput("t4 pending +405", {28'd0, pendingO}, 32'd0);
      period = '0;
      waitCycles(10);
      checkOutput("t4 issued", issuedO, 32'd11);

      $display("[TB] reset during pulse");
      applyStimulus(2);
      checkOutput("t5 soft before reset", {31'd0, softO}, 32'd1);
      checkOutput("t5 pending before reset", {28'd0, pendingO}, 32'd1);
      rstN = 1'b0;
      nextCycle();
      rstN = 1'b1;
      checkOutput("t5 soft after reset", {31'd0, softO}, 32'd0);
      checkOutput("t5 pending after reset", {28'd0, pendingO}, 32'd0);
      checkOutput("t5 issued after reset", issuedO, 32'd0);
      checkOutput("t5 busy after reset", {31'd0, busyO}, 32'd0);
      waitCycles(8);
      checkOutput("t5 soft idle", {31'd0, softO}, 32'd0);
      applyStimulus(1);
      checkOutput("t5 soft new strobe", {31'd0, softO}, 32'd1);
      waitCycles(5);
      checkOutput("t5 issued", issuedO, 32'd1);

      $display("[TB] period change mid-count");
      period = 32'd100;
      waitCycles(50);
      period = 32'd10;
      waitCycles(10);
      checkOutput("t6 soft +60", {31'd0, softO}, 32'd0);
      nextCycle();
      checkOutput("t6 soft +61", {31'd0, softO}, 32'd1);
      period = '0;
      waitCycles(10);
      checkOutput("t6 issued", issuedO, 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
